// File: rtl/LIB_pkg.sv
// Shared definitions for the router library blocks.
//   RADIX_DEF / CREDITS_DEF : default port count and downstream buffer depth
//   onehot_t                : one bit per port, index 0 = core ... 4 = west
//   CORE..WEST              : port index constants
//   credit_width()          : counter width able to hold 0..credits
package LIB_pkg;

    localparam int RADIX_DEF   = 5;
    localparam int CREDITS_DEF = 4;

    typedef logic [0:RADIX_DEF-1] onehot_t;

    localparam int CORE  = 0;
    localparam int NORTH = 1;
    localparam int EAST  = 2;
    localparam int SOUTH = 3;
    localparam int WEST  = 4;

    function automatic int credit_width(input int credits);
        return $clog2(credits + 1);
    endfunction

endpackage

// File: rtl/lib_arbiter_rr_onehot.sv
// Round-robin arbiter for one switch output.
//   clk, reset_n : clock, synchronous active-low reset (pointer -> 0)
//   i_req        : request column, one bit per input
//   i_en         : output may grant this cycle (credit available, not in reset)
//   o_grant      : one-hot grant column, combinational in the request cycle
// The pointer marks the highest-priority input; it moves to one past the
// winner after every grant.
module lib_arbiter_rr_onehot #(
    parameter int N = 5
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [0:N-1] i_req,
    input  logic         i_en,
    output logic [0:N-1] o_grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_next_ptr;
    logic [0:N-1]  w_grant;
    logic          w_found;

    // Two passes: first inputs at/after the pointer, then the wrapped-around
    // ones below it. Together they give the modulo-N search order.
    always_comb begin
        w_grant    = '0;
        w_found    = 1'b0;
        w_next_ptr = r_ptr;
        for (int i = 0; i < N; i++) begin
            if (!w_found && i_en && i_req[i] && (i >= int'(r_ptr))) begin
                w_grant[i] = 1'b1;
                w_found    = 1'b1;
                w_next_ptr = (i == N-1) ? '0 : PW'(i + 1);
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!w_found && i_en && i_req[i] && (i < int'(r_ptr))) begin
                w_grant[i] = 1'b1;
                w_found    = 1'b1;
                w_next_ptr = (i == N-1) ? '0 : PW'(i + 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ptr <= '0;
        end else if (w_found) begin
            r_ptr <= w_next_ptr;
        end
    end

    assign o_grant = w_grant;

endmodule

// File: rtl/lib_switch_allocator_onehot.sv
// Per-output round-robin switch allocator feeding the one-hot crossbar.
//   clk, reset_n  : clock, synchronous active-low reset
//   i_req[in]     : one-hot requested output per input (zero = idle)
//   i_credit[out] : downstream freed one slot on that output
//   o_grant[in]   : one-hot granted output per input (switch select)
//   o_pop[in]     : pop the input FIFO head (OR of o_grant[in])
//   o_credit_err  : sticky, credit overflow or malformed request seen
module lib_switch_allocator_onehot
    import LIB_pkg::*;
#(
    parameter int RADIX   = RADIX_DEF,
    parameter int CREDITS = CREDITS_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [0:RADIX-1] i_req    [0:RADIX-1],
    input  logic [0:RADIX-1] i_credit,
    output logic [0:RADIX-1] o_grant  [0:RADIX-1],
    output logic [0:RADIX-1] o_pop,
    output logic             o_credit_err
);

    localparam int            CW      = credit_width(CREDITS);
    localparam logic [CW-1:0] CNT_MAX = CW'(CREDITS);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [CW-1:0]    r_cnt     [0:RADIX-1];
    logic             r_err;
    logic [0:RADIX-1] w_req_ok  [0:RADIX-1];
    logic [0:RADIX-1] w_req_col [0:RADIX-1];
    logic [0:RADIX-1] w_gnt_col [0:RADIX-1];
    logic [0:RADIX-1] w_malformed;
    logic [0:RADIX-1] w_granted;
    logic [0:RADIX-1] w_en;
    logic [0:RADIX-1] w_full;

    // Malformed rows are dropped before arbitration so they never win.
    always_comb begin
        for (int r = 0; r < RADIX; r++) begin
            w_malformed[r] = ($countones(i_req[r]) > 1);
            w_req_ok[r]    = w_malformed[r] ? '0 : i_req[r];
        end
        for (int c = 0; c < RADIX; c++) begin
            for (int r = 0; r < RADIX; r++) begin
                w_req_col[c][r] = w_req_ok[r][c];
            end
        end
    end

    for (genvar g = 0; g < RADIX; g++) begin : g_arb
        // Reset gates the enable so no grant (and no pop) leaks out while reset.
        assign w_en[g]      = reset_n && (r_cnt[g] != '0);
        assign w_full[g]    = (r_cnt[g] == CNT_MAX);
        assign w_granted[g] = |w_gnt_col[g];

        lib_arbiter_rr_onehot #(
            .N (RADIX)
        ) u_arb (
            .clk     (clk),
            .reset_n (reset_n),
            .i_req   (w_req_col[g]),
            .i_en    (w_en[g]),
            .o_grant (w_gnt_col[g])
        );
    end

    always_comb begin
        for (int r = 0; r < RADIX; r++) begin
            for (int c = 0; c < RADIX; c++) begin
                o_grant[r][c] = w_gnt_col[c][r];
            end
        end
        for (int r = 0; r < RADIX; r++) begin
            o_pop[r] = 1'b0;
            for (int c = 0; c < RADIX; c++) begin
                o_pop[r] = o_pop[r] | w_gnt_col[c][r];
            end
        end
    end

    // A grant consumes a credit, a return adds one; both together cancel.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int c = 0; c < RADIX; c++) begin
                r_cnt[c] <= CNT_MAX;
            end
            r_err <= 1'b0;
        end else begin
            for (int c = 0; c < RADIX; c++) begin
                if (w_granted[c] && !i_credit[c]) begin
                    r_cnt[c] <= r_cnt[c] - CNT_ONE;
                end else if (!w_granted[c] && i_credit[c] && !w_full[c]) begin
                    r_cnt[c] <= r_cnt[c] + CNT_ONE;
                end
            end
            if ((|w_malformed) || (|(i_credit & ~w_granted & w_full))) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_credit_err = r_err;

endmodule

// File: tb/tb_lib_switch_allocator_onehot.sv
module tb_lib_switch_allocator_onehot;
    import LIB_pkg::*;

    localparam int R = 5;
    localparam int C = 4;

    logic    clk = 1'b0;
    logic    reset_n = 1'b0;
    onehot_t i_req [0:R-1];
    onehot_t i_credit;
    onehot_t o_grant [0:R-1];
    onehot_t o_pop;
    logic    o_credit_err;

    lib_switch_allocator_onehot #(
        .RADIX   (R),
        .CREDITS (C)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_req        (i_req),
        .i_credit     (i_credit),
        .o_grant      (o_grant),
        .o_pop        (o_pop),
        .o_credit_err (o_credit_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [0:R-1][0:R-1] grant;
        logic [0:R-1]        pop;
        logic                err;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference state: what the allocator should hold between edges.
    int   m_ptr [0:R-1];
    int   m_cnt [0:R-1];
    logic m_err;

    function automatic int ones(input logic [0:R-1] v);
        int n = 0;
        for (int b = 0; b < R; b++) n += int'(v[b]);
        return n;
    endfunction

    task automatic model_reset();
        for (int o = 0; o < R; o++) begin
            m_ptr[o] = 0;
            m_cnt[o] = C;
        end
        m_err = 1'b0;
    endtask

    // Drive one cycle of stimulus, queue the expected response, advance model.
    task automatic step(input logic [0:R-1][0:R-1] req, input logic [0:R-1] cred, input logic rstn);
        exp_t e;
        int   win [0:R-1];
        int   best_d;
        int   d;
        @(negedge clk);
        for (int i = 0; i < R; i++) i_req[i] = req[i];
        i_credit = cred;
        reset_n  = rstn;

        e = '0;
        for (int o = 0; o < R; o++) begin
            win[o] = -1;
            if (rstn && m_cnt[o] > 0) begin
                best_d = R;
                for (int in = 0; in < R; in++) begin
                    if (ones(req[in]) == 1 && req[in][o]) begin
                        d = (in - m_ptr[o] + R) % R;
                        if (d < best_d) begin
                            best_d = d;
                            win[o] = in;
                        end
                    end
                end
            end
            if (win[o] >= 0) e.grant[win[o]][o] = 1'b1;
        end
        for (int in = 0; in < R; in++) e.pop[in] = |e.grant[in];
        e.err = m_err;
        q.push_back(e);

        if (!rstn) begin
            model_reset();
        end else begin
            for (int in = 0; in < R; in++) if (ones(req[in]) > 1) m_err = 1'b1;
            for (int o = 0; o < R; o++) begin
                if (win[o] >= 0) m_ptr[o] = (win[o] + 1) % R;
                if (win[o] >= 0 && !cred[o]) begin
                    m_cnt[o] = m_cnt[o] - 1;
                end else if (win[o] < 0 && cred[o]) begin
                    if (m_cnt[o] == C) m_err = 1'b1;
                    else m_cnt[o] = m_cnt[o] + 1;
                end
            end
        end
    endtask

    // Monitor: outputs are valid every cycle; sample mid-low-phase.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                for (int i = 0; i < R; i++) begin
                    n_checks++;
                    if (o_grant[i] !== e.grant[i]) begin
                        n_errors++;
                        $display("FAIL grant[%0d] t=%0t got=%b exp=%b", i, $time, o_grant[i], e.grant[i]);
                    end
                end
                n_checks++;
                if (o_pop !== e.pop) begin
                    n_errors++;
                    $display("FAIL pop t=%0t got=%b exp=%b", $time, o_pop, e.pop);
                end
                n_checks++;
                if (o_credit_err !== e.err) begin
                    n_errors++;
                    $display("FAIL credit_err t=%0t got=%b exp=%b", $time, o_credit_err, e.err);
                end
            end
        end
    end

    initial begin
        logic [0:R-1][0:R-1] rq;
        logic [0:R-1]        cr;
        logic                rs;
        int                  b1;
        int                  b2;
        int                  sel;

        // reset_n is low from time 0, so the first edge resets the DUT
        for (int i = 0; i < R; i++) i_req[i] = '1;
        i_credit = '0;
        model_reset();

        // Reset held with every input requesting everything
        rq = '1;
        step(rq, '0, 1'b0);
        step(rq, '0, 1'b0);

        // Single request north -> east
        rq = '0;
        rq[NORTH] = 5'b00100;
        step(rq, '0, 1'b1);
        step('0, '0, 1'b1);

        // Three inputs contend for west with a credit returned every cycle
        rq = '0;
        rq[CORE]  = 5'b00001;
        rq[NORTH] = 5'b00001;
        rq[SOUTH] = 5'b00001;
        cr = '0;
        cr[WEST] = 1'b1;
        repeat (4) step(rq, cr, 1'b1);
        // Reset mid-traffic, then arbitration restarts from input 0
        step(rq, cr, 1'b0);
        repeat (4) step(rq, cr, 1'b1);

        // Credit exhaustion on core output, then a single credit return
        rq = '0;
        rq[EAST] = 5'b10000;
        repeat (6) step(rq, '0, 1'b1);
        cr = '0;
        cr[CORE] = 1'b1;
        step(rq, cr, 1'b1);
        repeat (3) step(rq, '0, 1'b1);

        // Grant and return together at credit 1, then overflow, then malformed
        step('0, '0, 1'b0);
        rq = '0;
        rq[CORE] = 5'b00010;
        repeat (3) step(rq, '0, 1'b1);
        cr = '0;
        cr[SOUTH] = 1'b1;
        step(rq, cr, 1'b1);
        step(rq, '0, 1'b1);
        step(rq, '0, 1'b1);
        cr = '0;
        cr[NORTH] = 1'b1;
        step('0, cr, 1'b1);
        step('0, '0, 1'b1);
        step('0, '0, 1'b0);
        rq = '0;
        rq[CORE] = 5'b00110;
        step(rq, '0, 1'b1);
        step('0, '0, 1'b1);
        step('0, '0, 1'b1);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            rq = '0;
            for (int in = 0; in < R; in++) begin
                sel = $urandom_range(0, 49);
                if (sel == 0) begin
                    b1 = $urandom_range(0, R-1);
                    b2 = (b1 + 1 + $urandom_range(0, R-2)) % R;
                    rq[in][b1] = 1'b1;
                    rq[in][b2] = 1'b1;
                end else if (sel >= 20) begin
                    rq[in][$urandom_range(0, R-1)] = 1'b1;
                end
            end
            cr = '0;
            for (int o = 0; o < R; o++) cr[o] = ($urandom_range(0, 2) == 0);
            rs = ($urandom_range(0, 59) != 0);
            step(rq, cr, rs);
        end
        step('0, '0, 1'b1);

        for (int k = 0; k < 20 && q.size() != 0; k++) @(posedge clk);
        if (q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
